demod_filter: RTL and testbench

DEMOD_FILTER -- requirements
Module: demod_filter

---
 rtl/demod_filter.sv | 166 ++++++++++++++++
 tb/tb_demod_filter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/demod_filter.sv
// demod_filter: deglitching filter for the raw PIE demodulator output.
//   2-flop synchronizer -> 3-bit saturating integrator -> hysteretic output.
//   Emits rise/fall strobes, measures the last low period, and flags carrier
//   loss after LOSS_CYCLES consecutive filtered-low cycles.
// Optional feature: define DEMOD_GLITCHCNT_EN to add the glitch_count port,
//   a saturating count of integrator excursions that did not toggle demodout.
module demod_filter #(
   parameter logic [9:0] LOSS_CYCLES = 10'd1000  // legal range 1..1023
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       demodin,
   input  logic       enable,
   output logic       demodout,
   output logic       rise_pulse,
   output logic       fall_pulse,
   output logic [9:0] low_width,
   output logic       carrier_lost
`ifdef DEMOD_GLITCHCNT_EN
   ,
   output logic [7:0] glitch_count
`endif
);

   localparam logic [2:0] CNT_MAX = 3'd7;
   localparam logic [9:0] LOW_MAX = 10'h3FF;

   logic       sync1_q, s_q;
   logic [2:0] cnt_q, cnt_d;
   logic       demod_q, demod_d;
   logic       rise_q, rise_d;
   logic       fall_q, fall_d;
   logic [9:0] lowcnt_q, lowcnt_d;
   logic [9:0] lw_q, lw_d;
   logic       lost_q, lost_d;
   logic [10:0] lw_inc;

   // Two-flop synchronizer; runs even while disabled so the filter resumes
   // from a settled sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         s_q     <= 1'b1;
      end else begin
         sync1_q <= demodin;
         s_q     <= sync1_q;
      end
   end

   // Integrator, hysteretic output and edge strobes. The output only moves
   // when the integrator reaches a rail, so excursions of up to 6 cycles are
   // absorbed. Disabled forces the idle (carrier present) state without
   // strobes.
   always_comb begin
      cnt_d   = cnt_q;
      demod_d = demod_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (!enable) begin
         cnt_d   = CNT_MAX;
         demod_d = 1'b1;
      end else begin
         if (s_q && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 3'd1;
         else if (!s_q && cnt_q != 3'd0)
            cnt_d = cnt_q - 3'd1;
         if (cnt_d == CNT_MAX)
            demod_d = 1'b1;
         else if (cnt_d == 3'd0)
            demod_d = 1'b0;
         rise_d = demod_d & ~demod_q;
         fall_d = ~demod_d & demod_q;
      end
   end

   // Low-period measurement and carrier-loss detection.
   // lowcnt is 0 in the first low cycle, so a low period of N cycles reads
   // N-1 just before the rise; low_width captures lowcnt+1 (saturated).
   always_comb begin
      lw_inc   = {1'b0, lowcnt_q} + 11'd1;
      lowcnt_d = lowcnt_q;
      lw_d     = lw_q;
      lost_d   = lost_q;
      if (!enable) begin
         lowcnt_d = 10'd0;
         lost_d   = 1'b0;
      end else begin
         if (fall_d)
            lowcnt_d = 10'd0;
         else if (!demod_q && lowcnt_q != LOW_MAX)
            lowcnt_d = lw_inc[9:0];

         if (rise_d)
            lw_d = lw_inc[10] ? LOW_MAX : lw_inc[9:0];

         if (rise_d)
            lost_d = 1'b0;
         else if (!demod_q && lowcnt_q >= (LOSS_CYCLES - 10'd1))
            lost_d = 1'b1;
      end
   end

   // Filter and measurement state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= CNT_MAX;
         demod_q  <= 1'b1;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         lowcnt_q <= 10'd0;
         lw_q     <= 10'd0;
         lost_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         demod_q  <= demod_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         lowcnt_q <= lowcnt_d;
         lw_q     <= lw_d;
         lost_q   <= lost_d;
      end
   end

   assign demodout     = demod_q;
   assign rise_pulse   = rise_q;
   assign fall_pulse   = fall_q;
   assign low_width    = lw_q;
   assign carrier_lost = lost_q;

`ifdef DEMOD_GLITCHCNT_EN
   logic       left_q, left_d;
   logic [7:0] gcnt_q, gcnt_d;
   logic [2:0] rail;

   // A glitch is an integrator trip away from the rail that matches demodout
   // and back again without the output toggling.
   always_comb begin
      rail   = demod_q ? CNT_MAX : 3'd0;
      left_d = left_q;
      gcnt_d = gcnt_q;
      if (!enable || rise_d || fall_d) begin
         left_d = 1'b0;
      end else if (cnt_d != rail) begin
         left_d = 1'b1;
      end else begin
         left_d = 1'b0;
         if (left_q && gcnt_q != 8'hFF)
            gcnt_d = gcnt_q + 8'd1;
      end
   end

   // Glitch tracking registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         left_q <= 1'b0;
         gcnt_q <= 8'd0;
      end else begin
         left_q <= left_d;
         gcnt_q <= gcnt_d;
      end
   end

   assign glitch_count = gcnt_q;
`endif

endmodule

// File: tb/tb_demod_filter.sv
// tb_demod_filter: randomized and directed stimulus for demod_filter, checked
// each cycle against a behavioural model built from timestamps of the
// filtered edges.
module tb_demod_filter;
   localparam int L = 1000;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       demodin;
   logic       enable;
   logic       demodout, rise_pulse, fall_pulse, carrier_lost;
   logic [9:0] low_width;
`ifdef DEMOD_GLITCHCNT_EN
   logic [7:0] glitch_count;
`endif

   demod_filter #(.LOSS_CYCLES(10'd1000)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .demodin      (demodin),
      .enable       (enable),
      .demodout     (demodout),
      .rise_pulse   (rise_pulse),
      .fall_pulse   (fall_pulse),
      .low_width    (low_width),
      .carrier_lost (carrier_lost)
`ifdef DEMOD_GLITCHCNT_EN
      ,
      .glitch_count (glitch_count)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: raw input delayed two samples, a saturating 0..7
   // level, output flips only at the rails; widths come from edge timestamps.
   int m_hist[$];
   int m_cnt, m_out, m_rise, m_fall, m_lw, m_cl, m_gc, m_dep;
   int cyc, fall_cyc;

   task automatic model_reset();
      m_hist   = '{1, 1};
      m_cnt    = 7;
      m_out    = 1;
      m_rise   = 0;
      m_fall   = 0;
      m_lw     = 0;
      m_cl     = 0;
      m_gc     = 0;
      m_dep    = 0;
      fall_cyc = cyc;
   endtask

   task automatic model_edge(input int din, input int en);
      int s_old, nc, no;
      s_old = m_hist[m_hist.size()-2];
      m_hist.push_back(din);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      cyc++;
      m_rise = 0;
      m_fall = 0;
      if (en == 0) begin
         m_cnt = 7;
         m_out = 1;
         m_cl  = 0;
         m_dep = 0;
      end else begin
         nc = m_cnt + (s_old != 0 ? 1 : -1);
         if (nc > 7) nc = 7;
         if (nc < 0) nc = 0;
         no = (nc == 7) ? 1 : (nc == 0) ? 0 : m_out;
         m_cnt = nc;
         if (no != m_out) begin
            m_dep = 0;
            if (no == 1) begin
               m_rise = 1;
               m_lw = (cyc - fall_cyc > 1023) ? 1023 : cyc - fall_cyc;
            end else begin
               m_fall = 1;
               fall_cyc = cyc;
            end
         end else if (m_cnt != (m_out != 0 ? 7 : 0)) begin
            m_dep = 1;
         end else if (m_dep != 0) begin
            m_dep = 0;
            if (m_gc < 255) m_gc++;
         end
         m_out = no;
         m_cl  = (m_out == 0 && (cyc - fall_cyc) >= L) ? 1 : 0;
      end
   endtask

   task automatic check_outs();
      chk("demodout", demodout, m_out);
      chk("rise_pulse", rise_pulse, m_rise);
      chk("fall_pulse", fall_pulse, m_fall);
      chk("low_width", low_width, m_lw);
      chk("carrier_lost", carrier_lost, m_cl);
`ifdef DEMOD_GLITCHCNT_EN
      chk("glitch_count", glitch_count, m_gc);
`endif
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_demodout"}, demodout, 1);
      chk({tag, "_rise"}, rise_pulse, 0);
      chk({tag, "_fall"}, fall_pulse, 0);
      chk({tag, "_low_width"}, low_width, 0);
      chk({tag, "_carrier_lost"}, carrier_lost, 0);
`ifdef DEMOD_GLITCHCNT_EN
      chk({tag, "_glitch"}, glitch_count, 0);
`endif
   endtask

   // One clock: drive, let the edge happen, advance the model, compare.
   task automatic step(input int din, input int en);
      demodin = din[0];
      enable  = en[0];
      @(posedge clk);
      model_edge(din, en);
      #1;
      check_outs();
   endtask

   initial begin
      cyc     = 0;
      reset_n = 1'b0;
      demodin = 1'b1;
      enable  = 1'b1;
      model_reset();
      #12;
      check_reset_vals("rst");
      @(negedge clk);
      reset_n = 1'b1;

      // Settled high: nothing happens
      repeat (100) step(1, 1);

      // 20-cycle low pulse: edges on the 9th clock, width 20
      for (int i = 1; i <= 20; i++) begin
         step(0, 1);
         if (i == 9) chk("fall_edge9", fall_pulse, 1);
         if (i == 8) chk("fall_edge8", demodout, 1);
      end
      for (int i = 1; i <= 30; i++) begin
         step(1, 1);
         if (i == 9) chk("rise_edge9", rise_pulse, 1);
      end
      chk("lw20", low_width, 20);

      // 6-cycle glitch is absorbed
      repeat (6) step(0, 1);
      repeat (20) step(1, 1);
      chk("glitch_demodout", demodout, 1);
`ifdef DEMOD_GLITCHCNT_EN
      chk("glitch_cnt1", glitch_count, 1);
`endif

      // Long low: carrier loss then recovery
      repeat (1200) step(0, 1);
      chk("lost_high", carrier_lost, 1);
      for (int i = 1; i <= 12; i++) begin
         step(1, 1);
         if (i == 9) begin
            chk("lost_rise", rise_pulse, 1);
            chk("lost_clear", carrier_lost, 0);
         end
      end
      chk("lw_sat", low_width, 1023);

      // Enable dropped during a low period
      repeat (50) step(0, 1);
      chk("en_low", demodout, 0);
      step(0, 0);
      chk("en_idle_out", demodout, 1);
      chk("en_idle_rise", rise_pulse, 0);
      chk("en_lw_hold", low_width, 1023);
      repeat (5) step(0, 0);
      repeat (20) step(1, 1);

      // Asynchronous reset while filtered low
      repeat (30) step(0, 1);
      chk("prerst_low", demodout, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_vals("arst");
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) step(1, 1);

      // Randomized levels, durations and occasional disable
      for (int k = 0; k < 80; k++) begin
         int lvl, dur, en;
         lvl = $urandom_range(0, 1);
         dur = $urandom_range(1, 14);
         en  = ($urandom_range(0, 19) != 0) ? 1 : 0;
         repeat (dur) step(lvl, en);
      end
      repeat (20) step(1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
